// File: rtl/stream_source.sv
// stream_source: valid/ready burst transmitter emitting seed + k*incr data beats.
// Optional macro STREAM_SOURCE_THROTTLE_EN inserts LFSR-driven gaps before beats.
module stream_source #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  cfg_len,
  input  logic [DATA_WIDTH-1:0] cfg_seed,
  input  logic [DATA_WIDTH-1:0] cfg_incr,
  input  logic                  abort,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic [LEN_WIDTH-1:0]  sent_count
);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

  state_t                state;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [DATA_WIDTH-1:0] incr_q;
  logic                  abort_pend;
  logic                  stall;
  logic                  handshake;
  logic [LEN_WIDTH-1:0]  count_next;

`ifdef STREAM_SOURCE_THROTTLE_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= 16'hACE1;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  assign stall = (lfsr[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  assign handshake  = out_valid && out_ready;
  assign count_next = sent_count + LEN_ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      len_q      <= '0;
      incr_q     <= '0;
      abort_pend <= 1'b0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      sent_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            len_q      <= cfg_len;
            incr_q     <= cfg_incr;
            sent_count <= '0;
            abort_pend <= 1'b0;
            out_data   <= cfg_seed;
            busy       <= 1'b1;
            if (cfg_len == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state     <= SEND;
              out_valid <= !stall;
              out_last  <= (cfg_len == LEN_ONE);
            end
          end
        end
        SEND: begin
          // Abort only ends the burst at a beat boundary; a pending beat is delivered first.
          if (handshake) begin
            sent_count <= count_next;
            if (count_next == len_q || abort || abort_pend) begin
              state     <= DONE;
              done      <= 1'b1;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
            end else begin
              out_data  <= out_data + incr_q;
              out_last  <= (count_next == len_q - LEN_ONE);
              out_valid <= !stall;
            end
          end else if (!out_valid) begin
            if (abort || abort_pend) begin
              state    <= DONE;
              done     <= 1'b1;
              out_last <= 1'b0;
            end else if (!stall) begin
              out_valid <= 1'b1;
            end
          end else if (abort) begin
            abort_pend <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stream_source.sv
// tb_stream_source: directed bench for stream_source with a beat-queue model
// checked on every handshake, plus literal cycle-level expectations.
module tb_stream_source;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] cfg_len;
  logic [31:0] cfg_seed;
  logic [31:0] cfg_incr;
  logic        abort;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        busy;
  logic        done;
  logic [15:0] sent_count;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } beat_t;

  beat_t       exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          model_count = 0;
  logic        last_seen = 1'b0;
  logic        prev_held = 1'b0;
  logic [31:0] prev_data;
  logic        prev_last;

  stream_source #(.DATA_WIDTH(32), .LEN_WIDTH(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .cfg_len    (cfg_len),
    .cfg_seed   (cfg_seed),
    .cfg_incr   (cfg_incr),
    .abort      (abort),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done),
    .sent_count (sent_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Loads the expected beat list for the burst, then pulses start for one edge.
  task automatic applyStimulus(input logic [15:0] len, input logic [31:0] seed, input logic [31:0] incr);
    exp_q.delete();
    model_count = 0;
    for (int k = 0; k < int'(len); k++) begin
      beat_t b;
      b.data = seed + incr * 32'(k);
      b.last = (k == int'(len) - 1);
      exp_q.push_back(b);
    end
    cfg_len  = len;
    cfg_seed = seed;
    cfg_incr = incr;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic waitDone(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("[TB] FAIL done_timeout: got no done pulse within %0d cycles", budget);
    end
  endtask

  // Outputs are sampled on the falling edge, where a visible valid&&ready means a transfer at the next rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_held = 1'b0;
    end else begin
      if (prev_held) begin
        checkOutput("hold_valid", 64'(out_valid), 64'd1);
        checkOutput("hold_data", 64'(out_data), 64'(prev_data));
        checkOutput("hold_last", 64'(out_last), 64'(prev_last));
      end
      if (busy) checkOutput("sent_count", 64'(sent_count), 64'(model_count));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_beat", 64'(out_data), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          beat_t b;
          b = exp_q.pop_front();
          checkOutput("beat_data", 64'(out_data), 64'(b.data));
          checkOutput("beat_last", 64'(out_last), 64'(b.last));
        end
        model_count++;
        if (out_last) last_seen = 1'b1;
      end
      prev_held = out_valid && !out_ready;
      prev_data = out_data;
      prev_last = out_last;
    end
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    cfg_len = '0; cfg_seed = '0; cfg_incr = '0;
    tick();
    tick();
    checkOutput("rst_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_last", 64'(out_last), 64'd0);
    checkOutput("rst_data", 64'(out_data), 64'd0);
    checkOutput("rst_count", 64'(sent_count), 64'd0);
    rst_n = 1'b1;
    tick();

    $display("[TB] basic 4-beat burst");
    applyStimulus(16'd4, 32'h10, 32'h4);
    checkOutput("t1_first_valid", 64'(out_valid), 64'd1);
    checkOutput("t1_first_data", 64'(out_data), 64'h10);
    tick(); tick(); tick();
    checkOutput("t1_last_data", 64'(out_data), 64'h1C);
    checkOutput("t1_last_flag", 64'(out_last), 64'd1);
    tick();
    checkOutput("t1_done", 64'(done), 64'd1);
    checkOutput("t1_busy_done", 64'(busy), 64'd1);
    checkOutput("t1_valid_off", 64'(out_valid), 64'd0);
    checkOutput("t1_count", 64'(sent_count), 64'd4);
    tick();
    checkOutput("t1_done_pulse", 64'(done), 64'd0);
    checkOutput("t1_idle_busy", 64'(busy), 64'd0);
    checkOutput("t1_drained", 64'(exp_q.size()), 64'd0);
    tick();

    $display("[TB] backpressure on second beat");
    applyStimulus(16'd4, 32'h10, 32'h4);
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkOutput("t2_held_data", 64'(out_data), 64'h14);
      checkOutput("t2_held_valid", 64'(out_valid), 64'd1);
      tick();
    end
    out_ready = 1'b1;
    waitDone(20);
    checkOutput("t2_count", 64'(sent_count), 64'd4);
    checkOutput("t2_drained", 64'(exp_q.size()), 64'd0);
    tick(); tick();

    $display("[TB] zero-length burst");
    applyStimulus(16'd0, 32'h55, 32'h1);
    checkOutput("t3_done", 64'(done), 64'd1);
    checkOutput("t3_busy", 64'(busy), 64'd1);
    checkOutput("t3_valid", 64'(out_valid), 64'd0);
    checkOutput("t3_count", 64'(sent_count), 64'd0);
    tick();
    checkOutput("t3_busy_off", 64'(busy), 64'd0);
    checkOutput("t3_done_off", 64'(done), 64'd0);
    tick();

    $display("[TB] wrap-around burst");
    applyStimulus(16'd3, 32'hFFFF_FFFE, 32'h1);
    checkOutput("t4_beat0", 64'(out_data), 64'hFFFF_FFFE);
    tick();
    checkOutput("t4_beat1", 64'(out_data), 64'hFFFF_FFFF);
    tick();
    checkOutput("t4_beat2", 64'(out_data), 64'h0);
    checkOutput("t4_beat2_last", 64'(out_last), 64'd1);
    waitDone(10);
    checkOutput("t4_count", 64'(sent_count), 64'd3);
    checkOutput("t4_drained", 64'(exp_q.size()), 64'd0);
    tick(); tick();

    $display("[TB] abort with pending beat, ignored restart");
    last_seen = 1'b0;
    applyStimulus(16'd10, 32'h100, 32'h10);
    tick(); tick(); tick();
    out_ready = 1'b0;
    checkOutput("t5_beat3", 64'(out_data), 64'h130);
    cfg_len = 16'd2; cfg_seed = 32'hDEAD; cfg_incr = 32'h1;
    start = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    while (exp_q.size() > 1) void'(exp_q.pop_back());
    tick();
    checkOutput("t5_pending_valid", 64'(out_valid), 64'd1);
    checkOutput("t5_pending_data", 64'(out_data), 64'h130);
    out_ready = 1'b1;
    waitDone(10);
    checkOutput("t5_count", 64'(sent_count), 64'd4);
    checkOutput("t5_no_last", 64'(last_seen), 64'd0);
    checkOutput("t5_drained", 64'(exp_q.size()), 64'd0);
    tick(); tick(); tick();
    checkOutput("t5_idle_valid", 64'(out_valid), 64'd0);
    checkOutput("t5_idle_busy", 64'(busy), 64'd0);

    $display("[TB] reset mid-burst");
    applyStimulus(16'd8, 32'h0, 32'h1);
    tick(); tick();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_valid", 64'(out_valid), 64'd0);
    checkOutput("t6_rst_busy", 64'(busy), 64'd0);
    checkOutput("t6_rst_count", 64'(sent_count), 64'd0);
    exp_q.delete();
    model_count = 0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    checkOutput("t6_no_resume_valid", 64'(out_valid), 64'd0);
    checkOutput("t6_no_resume_busy", 64'(busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
